// File: rtl/lane_vote_rx.sv
// Majority-voting receiver for LANES replicated LSB-first serial lanes.
// It assembles W-bit frames, flags lane disagreement, and counts frames delivered with a mismatch.
module lane_vote_rx #(
  parameter int LANES = 3,
  parameter int W     = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_start,
  input  logic [LANES-1:0] in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_mismatch,
  output logic             out_tie,
  output logic             frame_abort,
  output logic [CW-1:0]    err_cnt
);

  localparam int CNTW = (W > 1) ? $clog2(W) : 1;
  localparam int ONW  = $clog2(LANES + 1);
  localparam logic [ONW-1:0]  HALF     = ONW'(LANES / 2);
  localparam logic [ONW-1:0]  ALL_ONES = ONW'(LANES);
  localparam bit              EVEN     = (LANES % 2) == 0;
  localparam logic [CNTW-1:0] LAST     = CNTW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    data_q, data_d;
  logic            mism_q, mism_d;
  logic            tie_q, tie_d;
  logic            abort_q, abort_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   err_q, err_d;

  logic [ONW-1:0]  ones;
  logic            vote_bit, bit_tie, bit_mism;
  logic            accept, start_frame;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < LANES; i++) ones = ones + ONW'(in_bit[i]);
  end

  assign vote_bit = ones > HALF;
  assign bit_tie  = EVEN && (ones == HALF);
  assign bit_mism = (ones != '0) && (ones != ALL_ONES);

  assign in_ready = (state_q == HOLD) ? out_ready : 1'b1;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    mism_d      = mism_q;
    tie_d       = tie_q;
    abort_d     = 1'b0;
    err_d       = err_q;
    start_frame = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && in_start) start_frame = 1'b1;
      end
      SHIFT: begin
        if (accept) begin
          if (in_start) begin
            start_frame = 1'b1;
            abort_d     = 1'b1;
          end else begin
            data_d[cnt_q] = vote_bit;
            mism_d        = mism_q | bit_mism;
            tie_d         = tie_q | bit_tie;
            cnt_d         = cnt_q + CNTW'(1);
            if (cnt_q == LAST) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (mism_q && (err_q != '1)) err_d = err_q + CW'(1);
          if (accept && in_start) start_frame = 1'b1;
          else                    state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new bit0 restarts the word and the per-frame flags, whichever state it arrives in.
    if (start_frame) begin
      data_d    = '0;
      data_d[0] = vote_bit;
      mism_d    = bit_mism;
      tie_d     = bit_tie;
      cnt_d     = CNTW'(1);
      state_d   = (W == 1) ? HOLD : SHIFT;
    end

    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mism_q  <= 1'b0;
      tie_q   <= 1'b0;
      abort_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mism_q  <= mism_d;
      tie_q   <= tie_d;
      abort_q <= abort_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_mismatch = mism_q;
  assign out_tie      = tie_q;
  assign frame_abort  = abort_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_lane_vote_rx.sv
// Bench for lane_vote_rx: a 3-lane and a 4-lane instance, with random frames checked
// against a per-bit vote model computed from lane words.
module tb_lane_vote_rx;

  typedef bit [7:0] lanes_t [4];

  logic       clk, rst_n;
  logic       in_valid, in_start, out_ready;
  logic [2:0] in_bit;
  logic       in_ready, out_valid, out_mismatch, out_tie, frame_abort;
  logic [7:0] out_data;
  logic [3:0] err_cnt;

  logic       in_valid4, in_start4, out_ready4;
  logic [3:0] in_bit4;
  logic       in_ready4, out_valid4, out_mismatch4, out_tie4, frame_abort4;
  logic [7:0] out_data4;
  logic [3:0] err_cnt4;

  int checks = 0;
  int failures = 0;
  bit [3:0] exp_err, exp_err4;

  lane_vote_rx #(.LANES(3), .W(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_start(in_start), .in_bit(in_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mismatch(out_mismatch),
    .out_tie(out_tie), .frame_abort(frame_abort), .err_cnt(err_cnt)
  );

  lane_vote_rx #(.LANES(4), .W(8), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_start(in_start4), .in_bit(in_bit4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_mismatch(out_mismatch4),
    .out_tie(out_tie4), .frame_abort(frame_abort4), .err_cnt(err_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count ones per bit position across n lane words.
  function automatic void vote_model(input lanes_t lw, input int n,
                                     output bit [7:0] word, output bit mism, output bit tie);
    word = '0; mism = 1'b0; tie = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int ones = 0;
      for (int l = 0; l < n; l++) ones += int'(lw[l][k]);
      if (2 * ones > n) word[k] = 1'b1;
      if (2 * ones == n) tie = 1'b1;
      if (ones != 0 && ones != n) mism = 1'b1;
    end
  endfunction

  function automatic bit [3:0] sat_inc(input bit [3:0] v, input bit m);
    return (m && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  function automatic lanes_t noisy_lanes(input bit [7:0] base);
    lanes_t lw;
    for (int l = 0; l < 4; l++)
      lw[l] = base ^ 8'($urandom & $urandom & $urandom);
    return lw;
  endfunction

  task automatic send3(input lanes_t lw, input int first, input int last, input bit with_start);
    for (int k = first; k <= last; k++) begin
      in_valid = 1'b1;
      in_start = with_start && (k == first);
      for (int l = 0; l < 3; l++) in_bit[l] = lw[l][k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send4(input lanes_t lw);
    for (int k = 0; k < 8; k++) begin
      in_valid4 = 1'b1;
      in_start4 = (k == 0);
      for (int l = 0; l < 4; l++) in_bit4[l] = lw[l][k];
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    in_start4 = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_start = 1'b0;
    in_valid4 = 1'b0;
    in_start4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = '0;
    exp_err4 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if ({out_mismatch, out_tie, frame_abort} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {out_mismatch, out_tie, frame_abort}); end
    checks++; if (err_cnt !== 4'h0) begin failures++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    checks++; if (out_valid4 !== 1'b0 || err_cnt4 !== 4'h0) begin failures++; $display("FAIL reset_dut4: got valid=%b err=%0d want 0/0", out_valid4, err_cnt4); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = '0;
    exp_err4 = '0;
  endtask

  task automatic test_basic();
    lanes_t lw;
    bit [7:0] ew; bit em, et;
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      if (f == 0) lw = '{8'hA5, 8'hA5, 8'hA5, 8'h00};
      else        lw = noisy_lanes(8'($urandom));
      vote_model(lw, 3, ew, em, et);
      send3(lw, 0, 6, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid f%0d: got %b want 0", f, out_valid); end
      send3(lw, 7, 7, 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid f%0d: got %b want 1", f, out_valid); end
      checks++; if (out_data !== ew) begin failures++; $display("FAIL basic_data f%0d: got %h want %h", f, out_data, ew); end
      checks++; if (out_mismatch !== em || out_tie !== 1'b0) begin failures++; $display("FAIL basic_flags f%0d: got m=%b t=%b want m=%b t=0", f, out_mismatch, out_tie, em); end
      idle_cycle();
      exp_err = sat_inc(exp_err, em);
      checks++; if (out_valid !== 1'b0 || err_cnt !== exp_err) begin failures++; $display("FAIL basic_deliver f%0d: got valid=%b err=%0d want 0/%0d", f, out_valid, err_cnt, exp_err); end
    end
  endtask

  task automatic test_saturate();
    lanes_t lw;
    do_reset();
    out_ready = 1'b1;
    lw = '{8'h3C, 8'h3C, 8'hBD, 8'h00};
    for (int f = 0; f < 16; f++) begin
      send3(lw, 0, 7, 1'b1);
      checks++; if (out_data !== 8'h3C || out_mismatch !== 1'b1) begin failures++; $display("FAIL sat_frame f%0d: got %h m=%b want 3c m=1", f, out_data, out_mismatch); end
      idle_cycle();
      exp_err = sat_inc(exp_err, 1'b1);
      if (f == 0 || f == 14 || f == 15) begin
        checks++; if (err_cnt !== exp_err) begin failures++; $display("FAIL sat_err_cnt f%0d: got %0d want %0d", f, err_cnt, exp_err); end
      end
    end
  endtask

  task automatic test_backpressure();
    lanes_t la, lb;
    bit [7:0] wa, wb; bit ma, ta, mb, tb;
    la = noisy_lanes(8'($urandom));
    lb = noisy_lanes(8'($urandom));
    vote_model(la, 3, wa, ma, ta);
    vote_model(lb, 3, wb, mb, tb);
    out_ready = 1'b0;
    send3(la, 0, 7, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_start = 1'b0; in_bit = 3'($urandom);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== wa || out_mismatch !== ma) begin failures++; $display("FAIL bp_hold c%0d: got v=%b %h m=%b want 1 %h m=%b", c, out_valid, out_data, out_mismatch, wa, ma); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_start = 1'b1;
    for (int l = 0; l < 3; l++) in_bit[l] = lb[l][0];
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    exp_err = sat_inc(exp_err, ma);
    checks++; if (out_valid !== 1'b0 || err_cnt !== exp_err) begin failures++; $display("FAIL bp_deliver_a: got v=%b err=%0d want 0/%0d", out_valid, err_cnt, exp_err); end
    send3(lb, 1, 7, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== wb || out_mismatch !== mb) begin failures++; $display("FAIL bp_frame_b: got v=%b %h m=%b want 1 %h m=%b", out_valid, out_data, out_mismatch, wb, mb); end
    idle_cycle();
    exp_err = sat_inc(exp_err, mb);
    checks++; if (err_cnt !== exp_err) begin failures++; $display("FAIL bp_err_cnt: got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_abort();
    lanes_t la, lb;
    bit [7:0] base, wb; bit mb, tb;
    int pulses = 0;
    bit early_valid = 1'b0;
    out_ready = 1'b1;
    base = 8'($urandom);
    la = '{base, base, base ^ 8'h01, 8'h00};
    base = 8'($urandom);
    lb = '{base, base, base, 8'h00};
    vote_model(lb, 3, wb, mb, tb);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_start = (k == 0);
      for (int l = 0; l < 3; l++) in_bit[l] = la[l][k];
      @(posedge clk); #1;
      pulses += int'(frame_abort);
      early_valid |= out_valid;
    end
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_start = (k == 0);
      for (int l = 0; l < 3; l++) in_bit[l] = lb[l][k];
      @(posedge clk); #1;
      if (k == 0) begin
        checks++; if (frame_abort !== 1'b1) begin failures++; $display("FAIL abort_pulse: got %b want 1", frame_abort); end
      end
      pulses += int'(frame_abort);
      if (k < 7) early_valid |= out_valid;
    end
    idle_cycle();
    pulses += int'(frame_abort);
    checks++; if (pulses != 1) begin failures++; $display("FAIL abort_pulse_count: got %0d want 1", pulses); end
    checks++; if (early_valid !== 1'b0) begin failures++; $display("FAIL abort_no_partial: got %b want 0", early_valid); end
    exp_err = sat_inc(exp_err, mb);
    checks++; if (err_cnt !== exp_err) begin failures++; $display("FAIL abort_err_cnt: got %0d want %0d", err_cnt, exp_err); end
    // Check delivered frame B: resend to observe in HOLD with out_ready low.
    out_ready = 1'b0;
    lb = '{base, base, base, 8'h00};
    send3(la, 0, 3, 1'b1);
    send3(lb, 0, 7, 1'b1);
    checks++; if (out_data !== wb || out_mismatch !== 1'b0 || out_tie !== 1'b0) begin failures++; $display("FAIL abort_frame_b: got %h m=%b t=%b want %h m=0 t=0", out_data, out_mismatch, out_tie, wb); end
    out_ready = 1'b1;
    idle_cycle();
  endtask

  task automatic test_tie();
    lanes_t lw;
    bit [7:0] ew; bit em, et;
    out_ready4 = 1'b1;
    for (int f = 0; f < 4; f++) begin
      if (f == 0) lw = '{8'h5A, 8'h5A, 8'h52, 8'h52};
      else        lw = noisy_lanes(8'($urandom));
      vote_model(lw, 4, ew, em, et);
      if (f == 0) begin
        checks++; if (ew !== 8'h52 || et !== 1'b1) begin failures++; $display("FAIL tie_model_sanity: got %h t=%b want 52 t=1", ew, et); end
      end
      send4(lw);
      checks++; if (out_valid4 !== 1'b1 || out_data4 !== ew) begin failures++; $display("FAIL tie_data f%0d: got v=%b %h want 1 %h", f, out_valid4, out_data4, ew); end
      checks++; if (out_tie4 !== et || out_mismatch4 !== em) begin failures++; $display("FAIL tie_flags f%0d: got t=%b m=%b want t=%b m=%b", f, out_tie4, out_mismatch4, et, em); end
      idle_cycle();
      exp_err4 = sat_inc(exp_err4, em);
      checks++; if (err_cnt4 !== exp_err4) begin failures++; $display("FAIL tie_err_cnt f%0d: got %0d want %0d", f, err_cnt4, exp_err4); end
    end
  endtask

  task automatic test_async_reset();
    lanes_t lw;
    int stray_valid = 0;
    out_ready = 1'b1;
    lw = '{8'h3C, 8'h3C, 8'hBD, 8'h00};
    send3(lw, 0, 7, 1'b1);
    idle_cycle();
    out_ready = 1'b0;
    lw = '{8'hC3, 8'hC3, 8'hC3, 8'h00};
    send3(lw, 0, 7, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin failures++; $display("FAIL async_outputs: got v=%b %h want 0 00", out_valid, out_data); end
    checks++; if (err_cnt !== 4'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL async_err_ready: got err=%0d rdy=%b want 0/1", err_cnt, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = '0; exp_err4 = '0;
    out_ready = 1'b1;
    send3(lw, 0, 2, 1'b1);
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_start = 1'b0; in_bit = 3'($urandom);
      @(posedge clk); #1;
      stray_valid += int'(out_valid);
    end
    checks++; if (stray_valid != 0) begin failures++; $display("FAIL async_no_start_ignored: got %0d valid cycles want 0", stray_valid); end
    lw = '{8'h96, 8'h96, 8'h96, 8'h00};
    send3(lw, 0, 7, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h96 || out_mismatch !== 1'b0) begin failures++; $display("FAIL async_new_frame: got v=%b %h m=%b want 1 96 0", out_valid, out_data, out_mismatch); end
    idle_cycle();
    checks++; if (err_cnt !== exp_err) begin failures++; $display("FAIL async_err_after: got %0d want %0d", err_cnt, exp_err); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_start = 1'b0; in_bit = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_start4 = 1'b0; in_bit4 = '0; out_ready4 = 1'b0;
    exp_err = '0; exp_err4 = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_abort();
    test_tie();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
